// File: rtl/weight_loader_pkg.sv
// Shared constants, loader state encoding and a count helper for weight_loader.
// Contents: DATA_W, ADDR_W, N_INPUT, N_OUT, ACT_DEPTH_DEF, CNT_W, ld_state_e, cnt_max().
package weight_loader_pkg;

    localparam int DATA_W        = 16;
    localparam int ADDR_W        = 18;
    localparam int N_INPUT       = 784;
    localparam int N_OUT         = 10;
    localparam int ACT_DEPTH_DEF = 1024;
    localparam int CNT_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1,
        ST_L2,
        ST_ACT,
        ST_CHK,
        ST_DONE
    } ld_state_e;

    function automatic logic [CNT_W-1:0] cnt_max(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Host word stream (valid/ready) feeding the weight loader.
// Signals: s_valid (host->loader), s_ready (loader->host), s_data (host->loader).
interface weight_loader_if #(
    parameter int DW = 16
) ();

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/weight_loader_nested_counter.sv
// Inner/outer counter pair: inner wraps at in_max_i and carries into outer.
// Ports: clk, reset (async low), clr_i, inc_i, in_max_i, out_max_i -> in_o, out_o, last_o.
module nested_counter
    import weight_loader_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] in_max_i,
    input  logic [CNT_W-1:0] out_max_i,
    output logic [CNT_W-1:0] in_o,
    output logic [CNT_W-1:0] out_o,
    output logic             last_o
);

    logic [CNT_W-1:0] in_q, in_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic             in_wrap;
    logic             out_wrap;

    assign in_wrap  = (in_q == in_max_i);
    assign out_wrap = (out_q == out_max_i);
    assign last_o   = in_wrap && out_wrap;
    assign in_o     = in_q;
    assign out_o    = out_q;

    // Both halves wrap to 0 on the last count, so the next
    // phase starts from zero without an explicit reload.
    always_comb begin
        in_d  = in_q;
        out_d = out_q;
        if (clr_i) begin
            in_d  = '0;
            out_d = '0;
        end else if (inc_i) begin
            if (in_wrap) begin
                in_d  = '0;
                out_d = out_wrap ? '0 : out_q + 1'b1;
            end else begin
                in_d = in_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q  <= '0;
            out_q <= '0;
        end else begin
            in_q  <= in_d;
            out_q <= out_d;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Turns a host word stream into L1 RAM, L2 RAM and activation LUT write strokes.
// Ports: clk, reset (async low), start, s (stream slave), en, we, active_we, addr, wdata,
//        busy, done, err. Option: WEIGHT_LOADER_CHECKSUM_EN adds a trailing checksum word.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int N_L1      = N_INPUT,
    parameter int N_L2      = N_OUT,
    parameter int L1_DEPTH  = 64,
    parameter int L2_DEPTH  = 64,
    parameter int ACT_DEPTH = ACT_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    weight_loader_if.slave       s,
    output logic [1:0]           en,
    output logic [N_L1+N_L2-1:0] we,
    output logic                 active_we,
    output logic [ADDR_W-1:0]    addr,
    output logic [DATA_W-1:0]    wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int NW = N_L1 + N_L2;

    ld_state_e state_q, state_d;

    logic [NW-1:0]     we_q, we_d;
    logic              act_q, act_d;
    logic [1:0]        en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;

    logic ph_l1, ph_l2, ph_act;
    logic accept, strobe, start_ok;

    logic [CNT_W-1:0] in_max, out_max;
    logic [CNT_W-1:0] inner, outer;
    logic             last;

    assign ph_l1  = (state_q == ST_L1);
    assign ph_l2  = (state_q == ST_L2);
    assign ph_act = (state_q == ST_ACT);

    assign s.s_ready = ph_l1 || ph_l2 || ph_act ||
                       (state_q == ST_CHK);
    assign accept    = s.s_valid && s.s_ready;
    assign strobe    = accept && (ph_l1 || ph_l2 || ph_act);
    assign start_ok  = start && ((state_q == ST_IDLE) ||
                                 (state_q == ST_DONE));
    assign busy      = (state_q != ST_IDLE) &&
                       (state_q != ST_DONE);

    // inner = RAM index, outer = address; ACT has a single "RAM".
    always_comb begin
        in_max  = '0;
        out_max = '0;
        unique case (1'b1)
            ph_l1: begin
                in_max  = cnt_max(N_L1);
                out_max = cnt_max(L1_DEPTH);
            end
            ph_l2: begin
                in_max  = cnt_max(N_L2);
                out_max = cnt_max(L2_DEPTH);
            end
            ph_act: begin
                out_max = cnt_max(ACT_DEPTH);
            end
            default: ;
        endcase
    end

    nested_counter u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (start_ok),
        .inc_i     (strobe),
        .in_max_i  (in_max),
        .out_max_i (out_max),
        .in_o      (inner),
        .out_o     (outer),
        .last_o    (last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_L1;
            end
            ST_L1: begin
                if (accept && last) state_d = ST_L2;
            end
            ST_L2: begin
                if (accept && last) state_d = ST_ACT;
            end
            ST_ACT: begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                if (accept && last) state_d = ST_CHK;
`else
                if (accept && last) state_d = ST_DONE;
`endif
            end
            ST_CHK: begin
                if (accept) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        we_d = '0;
        for (int k = 0; k < N_L1; k++) begin
            we_d[k] = accept && ph_l1 && (inner == CNT_W'(k));
        end
        for (int k = 0; k < N_L2; k++) begin
            we_d[N_L1+k] = accept && ph_l2 &&
                           (inner == CNT_W'(k));
        end
        act_d   = accept && ph_act;
        en_d    = {ph_l2, ph_l1};
        addr_d  = strobe ? ADDR_W'(outer) : addr_q;
        wdata_d = strobe ? s.s_data : wdata_q;
        // Cleared on the same edge that a restart leaves DONE.
        done_d  = (state_q == ST_DONE) && !start;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= '0;
            act_q   <= 1'b0;
            en_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            act_q   <= act_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign we        = we_q;
    assign active_we = act_q;
    assign en        = en_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign done      = done_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;

    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (start_ok) begin
            sum_d = '0;
            err_d = 1'b0;
        end else if (strobe) begin
            sum_d = sum_q + s.s_data;
        end else if (accept && (state_q == ST_CHK)) begin
            err_d = (s.s_data != sum_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: small-parameter instance plus a default-parameter instance.
// Drives the stream interfaces, checks strokes, done/busy/ready and the beat totals.
module tb_weight_loader;
    import weight_loader_pkg::*;

    localparam int NL1 = 4;
    localparam int NL2 = 2;
    localparam int NW  = NL1 + NL2;
    localparam int PAY = 13;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam int TOTAL   = PAY + 1;
    localparam int BIG_TOT = 51840 + 1;
`else
    localparam int TOTAL   = PAY;
    localparam int BIG_TOT = 51840;
`endif
    localparam int BW = N_INPUT + N_OUT;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic big_start = 1'b0;

    always #5 clk = ~clk;

    weight_loader_if #(.DW(DATA_W)) sif ();
    weight_loader_if #(.DW(DATA_W)) bif ();

    logic [1:0]        en;
    logic [NW-1:0]     we;
    logic              active_we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy, done, err;

    logic [1:0]        b_en;
    logic [BW-1:0]     b_we;
    logic              b_active_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_busy, b_done, b_err;

    weight_loader #(
        .N_L1(NL1), .N_L2(NL2), .L1_DEPTH(2),
        .L2_DEPTH(1), .ACT_DEPTH(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .s(sif),
        .en(en), .we(we), .active_we(active_we),
        .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .err(err)
    );

    weight_loader big (
        .clk(clk), .reset(reset), .start(big_start), .s(bif),
        .en(b_en), .we(b_we), .active_we(b_active_we),
        .addr(b_addr), .wdata(b_wdata), .busy(b_busy),
        .done(b_done), .err(b_err)
    );

    int checks = 0;
    int errors = 0;

    // Hand-derived stroke order for 4x2 L1, 2x1 L2, 3-entry LUT.
    int exp_we   [PAY] = '{1, 2, 4, 8, 1, 2, 4, 8, 16, 32, 0, 0, 0};
    int exp_act  [PAY] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int exp_addr [PAY] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 2};
    int exp_en   [PAY] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_ready", 32'(sif.s_ready), 1);
        chk("start_done_clr", 32'(done), 0);
        chk("start_err_clr", 32'(err), 0);
    endtask

    task automatic run_seq(input bit toggle, input bit pulse,
                           input logic [15:0] chkw);
        int n   = 0;
        int cyc = 0;
        bit v;
        bit acc;
        while (n < TOTAL && cyc < 200) begin
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            sif.s_valid = v;
            sif.s_data  = (n < PAY) ? 16'(n + 1) : chkw;
            start = pulse && (cyc == 4);
            acc = v && sif.s_ready;
            tick();
            start = 1'b0;
            if (acc) begin
                if (n < PAY) begin
                    chk($sformatf("we[%0d]", n), 32'(we), exp_we[n]);
                    chk($sformatf("act[%0d]", n), 32'(active_we),
                        exp_act[n]);
                    chk($sformatf("addr[%0d]", n), 32'(addr),
                        exp_addr[n]);
                    chk($sformatf("wdata[%0d]", n), 32'(wdata), n + 1);
                    chk($sformatf("en[%0d]", n), 32'(en), exp_en[n]);
                end else begin
                    chk("chk_no_strobe", 32'({active_we, we}), 0);
                end
                n++;
            end else begin
                chk("bubble_no_strobe", 32'({active_we, we}), 0);
            end
            cyc++;
        end
        sif.s_valid = 1'b0;
        chk("beats", n, TOTAL);
        chk("done_not_yet", 32'(done), 0);
        tick();
        chk("done", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_ready", 32'(sif.s_ready), 0);
    endtask

    initial begin
        int cnt;
        int cyc;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        bif.s_valid = 1'b0;
        bif.s_data  = '0;
        tick();
        tick();
        chk("rst_en", 32'(en), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_act", 32'(active_we), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(sif.s_ready), 0);
        reset = 1'b1;
        tick();
        chk("idle_ready", 32'(sif.s_ready), 0);

        // Streaming load, then done must hold while idle.
        do_start();
        run_seq(1'b0, 1'b0, 16'h005B);
        chk("t1_err", 32'(err), 0);
        tick();
        chk("t1_done_hold", 32'(done), 1);

        // Every other cycle valid.
        do_start();
        run_seq(1'b1, 1'b0, 16'h005B);

        // start while busy must be ignored.
        do_start();
        run_seq(1'b0, 1'b1, 16'h005B);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
        // Wrong checksum word flags err, done still rises.
        do_start();
        run_seq(1'b0, 1'b0, 16'h005C);
        chk("t5_err", 32'(err), 1);
        do_start();
        run_seq(1'b0, 1'b0, 16'h005B);
        chk("t5_err_clr", 32'(err), 0);
`endif

        // Reset while the second L2 beat is in flight.
        do_start();
        for (int i = 0; i < 9; i++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = 16'(i + 1);
            tick();
        end
        chk("t3_l2_first", 32'(we), 32'h10);
        sif.s_data = 16'd10;
        #2;
        reset = 1'b0;
        #1;
        chk("t3_en", 32'(en), 0);
        chk("t3_we", 32'(we), 0);
        chk("t3_act", 32'(active_we), 0);
        chk("t3_addr", 32'(addr), 0);
        chk("t3_wdata", 32'(wdata), 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_ready", 32'(sif.s_ready), 0);
        sif.s_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        do_start();
        sif.s_valid = 1'b1;
        sif.s_data  = 16'h00A5;
        tick();
        sif.s_valid = 1'b0;
        chk("t3_re_we", 32'(we), 1);
        chk("t3_re_addr", 32'(addr), 0);
        chk("t3_re_wdata", 32'(wdata), 32'hA5);
        chk("t3_re_en", 32'(en), 1);

        // Full-size instance: count accepted beats until done.
        big_start = 1'b1;
        tick();
        big_start = 1'b0;
        cnt = 0;
        cyc = 0;
        bif.s_valid = 1'b1;
        bif.s_data  = '0;
        while (!b_done && cyc < 60000) begin
            if (bif.s_ready) cnt++;
            tick();
            cyc++;
        end
        chk("big_beats", cnt, BIG_TOT);
        chk("big_done", 32'(b_done), 1);
        chk("big_ready", 32'(bif.s_ready), 0);
        chk("big_busy", 32'(b_busy), 0);
        chk("big_quiet", 32'({b_active_we, |b_we}), 0);
        bif.s_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
